// File: rtl/ysyx_25020081_regfile_sb.sv
// Register file with NR_READ combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending scoreboard; cleared after reset.
module ysyx_25020081_regfile_sb #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NR_READ       = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wen,
    input  logic [RF_ADDR_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [NR_READ*RF_ADDR_WIDTH-1:0]   raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]      rdata,
    output logic [NR_READ-1:0]                 rpend,
    input  logic                               set_en,
    input  logic [RF_ADDR_WIDTH-1:0]           set_addr,
    output logic                               init_busy
);
    localparam int DEPTH = 2 ** RF_ADDR_WIDTH;
    localparam logic [RF_ADDR_WIDTH:0] LAST_IDX = (RF_ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                   state_reg, state_next;
    logic [RF_ADDR_WIDTH:0]   cnt_reg, cnt_next;
    logic [DEPTH-1:0]         pend_reg, pend_next;
    logic [DATA_WIDTH-1:0]    rf [DEPTH];

    logic                     rf_we;
    logic [RF_ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]    rf_wdata;

    logic wr_ok, set_ok;
    assign wr_ok  = wen    && !(ZERO_REG != 0 && waddr    == '0);
    assign set_ok = set_en && !(ZERO_REG != 0 && set_addr == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        rf_we      = 1'b0;
        rf_waddr   = waddr;
        rf_wdata   = wdata;
        case (state_reg)
            CLEAR: begin
                rf_we    = 1'b1;
                rf_waddr = cnt_reg[RF_ADDR_WIDTH-1:0];
                rf_wdata = '0;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX)
                    state_next = RUN;
            end
            default: begin
                if (wr_ok) begin
                    rf_we            = 1'b1;
                    pend_next[waddr] = 1'b0;
                end
                // Applied after the write so a new producer on the same register wins.
                if (set_ok)
                    pend_next[set_addr] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rf_we)
            rf[rf_waddr] <= rf_wdata;
    end

    assign init_busy = (state_reg == CLEAR);

    generate
        for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
            logic [RF_ADDR_WIDTH-1:0] a;
            logic [DATA_WIDTH-1:0]    rd;
            logic                     rp;

            assign a = raddr[gi*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];

            always_comb begin
                rd = rf[a];
                rp = pend_reg[a];
                if (state_reg == CLEAR) begin
                    rd = '0;
                    rp = 1'b0;
                end else if (ZERO_REG != 0 && a == '0) begin
                    rd = '0;
                    rp = 1'b0;
                end else if (BYPASS != 0 && wen && waddr == a) begin
                    rd = wdata;
                    rp = 1'b0;
                end
            end

            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
            assign rpend[gi] = rp;
        end
    endgenerate
endmodule

// File: tb/tb_ysyx_25020081_regfile_sb.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and
// compares every read port and init_busy against a rule-level model each cycle.
module tb_ysyx_25020081_regfile_sb;
    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rpend_b, rpend_n;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        busy_b, busy_n;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_25020081_regfile_sb dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rpend(rpend_b),
        .set_en(set_en), .set_addr(set_addr), .init_busy(busy_b)
    );

    ysyx_25020081_regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rpend(rpend_n),
        .set_en(set_en), .set_addr(set_addr), .init_busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: architectural contents, pending flags, clear cycles left.
    logic [31:0] m_rf [32];
    logic        m_pend [32];
    int          m_busy_left;
    bit          m_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_port(input bit byp, input logic [4:0] a,
                               output logic [31:0] d, output logic p);
        if (m_busy_left > 0 || a == 5'd0) begin
            d = 32'd0; p = 1'b0;
        end else if (byp && wen && waddr == a) begin
            d = wdata; p = 1'b0;
        end else begin
            d = m_rf[a]; p = m_pend[a];
        end
    endtask

    task automatic check_all();
        logic [31:0] d;
        logic        p;
        check("busy_b", {31'd0, busy_b}, {31'd0, m_busy_left > 0});
        check("busy_n", {31'd0, busy_n}, {31'd0, m_busy_left > 0});
        for (int i = 0; i < 2; i++) begin
            expect_port(1'b1, raddr[i*5 +: 5], d, p);
            check($sformatf("byp rdata%0d a=%0d", i, raddr[i*5 +: 5]), rdata_b[i*32 +: 32], d);
            check($sformatf("byp rpend%0d a=%0d", i, raddr[i*5 +: 5]), {31'd0, rpend_b[i]}, {31'd0, p});
            expect_port(1'b0, raddr[i*5 +: 5], d, p);
            check($sformatf("nobyp rdata%0d a=%0d", i, raddr[i*5 +: 5]), rdata_n[i*32 +: 32], d);
            check($sformatf("nobyp rpend%0d a=%0d", i, raddr[i*5 +: 5]), {31'd0, rpend_n[i]}, {31'd0, p});
        end
    endtask

    task automatic update_model();
        if (rst) begin
            m_valid     = 1;
            m_busy_left = 32;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0)
                for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (wen && waddr != 5'd0) begin
                m_rf[waddr]   = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (set_en && set_addr != 5'd0)
                m_pend[set_addr] = 1'b1;
        end
    endtask

    // One clock: apply inputs, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic se, input logic [4:0] sa);
        rst = r; wen = we; waddr = wa; wdata = wd;
        raddr = {ra1, ra0}; set_en = se; set_addr = sa;
        @(negedge clk);
        if (m_valid) check_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 0);
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0; set_en = 1'b0; set_addr = '0;
        #1;
        // Power-on reset for two cycles, then a clear with writes/sets attempted.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 5, 32'h5555_5555, 5, 5, 1, 5);
        for (int i = 0; i < 33; i++)
            cycle(0, 1, 5'($urandom), $urandom, 5'($urandom), 5, 1, 5'($urandom));
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);

        // Reset in the middle of a clear restarts the full sequence.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(34);

        // Directed: write/read, zero register, bypass, scoreboard.
        cycle(0, 1, 3, 32'hDEAD_BEEF, 3, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 3, 0, 0);
        cycle(0, 1, 0, 32'h0000_1234, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 7, 32'h1111_2222, 7, 7, 0, 0);
        cycle(0, 1, 7, 32'hA5A5_A5A5, 3, 7, 0, 0);
        cycle(0, 0, 0, 0, 7, 7, 0, 0);
        cycle(0, 0, 0, 0, 9, 9, 1, 9);
        cycle(0, 0, 0, 0, 9, 9, 0, 0);
        cycle(0, 1, 9, 32'h0000_0099, 9, 9, 0, 0);
        cycle(0, 0, 0, 0, 9, 9, 0, 0);
        cycle(0, 1, 9, 32'h0000_0999, 9, 9, 1, 9);
        cycle(0, 0, 0, 0, 9, 9, 1, 12);
        cycle(1, 0, 0, 0, 9, 12, 0, 0);
        idle(33);
        cycle(0, 0, 0, 0, 9, 12, 0, 0);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] wa, sa, r0, r1;
            wa = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            sa = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            r0 = ($urandom % 2 == 0) ? wa : 5'($urandom_range(0, 9));
            r1 = ($urandom % 3 == 0) ? sa : 5'($urandom_range(0, 9));
            cycle(($urandom % 400) == 0, 1'($urandom), wa, $urandom, r0, r1,
                  ($urandom % 3) == 0, sa);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
